// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the fifo write-port arbiter.
// The stats counter build option is selected with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int STAT_W = 16;

  // Burst counter width for a given burst limit: clog2(max_burst)+1.
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotate-priority encoder: first set req bit strictly after 'last', wrapping mod N.
module fifo_arb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last,
  output logic [2:0]   idx,
  output logic         any
);

  always_comb begin
    int c;
    c   = 0;
    idx = '0;
    any = 1'b0;
    // k runs to N so the previous owner is considered last.
    for (int k = 1; k <= N; k++) begin
      c = (int'(last) + k) % N;
      if (!any && req[c]) begin
        any = 1'b1;
        idx = 3'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one fifo write port among N requesters.
// Define FIFO_ARB_STATS_EN to build the per-requester saturating accepted-word counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 64,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              res,
  input  logic [N-1:0]      req,
  input  logic [N*W-1:0]    din,
  output logic [N-1:0]      ack,
  input  logic              fifo_full,
  output logic              shift_in,
  output logic [W-1:0]      data_in,
  output logic [2:0]        owner,
  output logic [N*16-1:0]   stat_cnt
);

  localparam int CNT_W = cnt_w(MAX_BURST);
  localparam int IW    = $clog2(N);

  state_t           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pick_idx;
  logic             pick_any;
  logic             push;
  logic [IW-1:0]    own_i;
  logic [W-1:0]     din_a [N];

  assign own_i = owner_q[IW-1:0];
  assign owner = owner_q;

  for (genvar i = 0; i < N; i++) begin : g_din
    assign din_a[i] = din[i*W +: W];
  end

  fifo_arb_rr_pick #(.N(N)) u_pick (
    .req  (req),
    .last (owner_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      owner_q <= 3'(N-1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    shift_in = 1'b0;
    data_in  = '0;
    ack      = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        push = req[own_i] & ~fifo_full;
        if (push) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MAX_BURST-1)) state_d = IDLE;
        end
        // A dropped request withdraws the word and ends the grant, even while stalled.
        if (!req[own_i]) state_d = IDLE;
        if (!res) begin
          shift_in   = push;
          data_in    = din_a[own_i];
          ack[own_i] = push;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [N];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < N; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (ack[i] && (stat_q[i] != '1)) stat_q[i] <= stat_q[i] + STAT_W'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_stat
    assign stat_cnt[i*STAT_W +: STAT_W] = stat_q[i];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (N=4, W=64, MAX_BURST=4); honours FIFO_ARB_STATS_EN.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           res;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   ack;
  logic           fifo_full;
  logic           shift_in;
  logic [W-1:0]   data_in;
  logic [2:0]     owner;
  logic [N*16-1:0] stat_cnt;

  fifo_wr_arbiter #(.N(N), .W(W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .res       (res),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .fifo_full (fifo_full),
    .shift_in  (shift_in),
    .data_in   (data_in),
    .owner     (owner),
    .stat_cnt  (stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         own;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] seq [N];
  logic [47:0] exp_seq [N];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Requester model: word i carries its index and a running sequence number.
  always_comb begin
    din = '0;
    for (int i = 0; i < N; i++) din[i*W +: W] = {16'(i), seq[i]};
  end

  initial for (int i = 0; i < N; i++) begin
    seq[i]     = '0;
    exp_seq[i] = '0;
  end

  always @(posedge clk)
    for (int i = 0; i < N; i++) if (ack[i]) seq[i] <= seq[i] + 48'd1;

  task automatic push_exp(input int who, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.own  = who;
      e.data = {16'(who), exp_seq[who]};
      exp_q.push_back(e);
      exp_seq[who] = exp_seq[who] + 48'd1;
    end
  endtask

  exp_t       mon_e;
  logic [3:0] mon_oh;

  always @(negedge clk) begin
    if (shift_in) begin
      chk("push_while_full", 64'(fifo_full), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_push", 64'(owner), 64'hFFFF);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_oh = 4'b0001 << mon_e.own;
        chk("data_in", data_in, mon_e.data);
        chk("owner", 64'(owner), 64'(mon_e.own));
        chk("ack", 64'(ack), 64'(mon_oh));
      end
    end else if (ack != '0) begin
      chk("stray_ack", 64'(ack), 64'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    res = 1'b1; req = '0; fifo_full = 1'b0;
    tick(2);
    res = 1'b0;
    #1;
    chk("rst_owner", 64'(owner), 64'd3);
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    chk("rst_shift_in", 64'(shift_in), 64'd0);
    chk("rst_data_in", data_in, 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_stat", 64'(stat_cnt), 64'd0);

    // Single requester 2 for 10 cycles: two 4-word bursts separated by arbitration.
    tick(1);
    push_exp(2, 8);
    req = 4'b0100;
    tick(10);
    req = '0;
    chk("t2_drain", 64'(exp_q.size()), 64'd0);

    // Reset mid-burst after two pushes.
    push_exp(2, 2);
    req = 4'b0100;
    tick(3);
    chk("t1_pre_shift", 64'(shift_in), 64'd1);
    res = 1'b1;
    #1;
    chk("t1_shift_in", 64'(shift_in), 64'd0);
    chk("t1_ack", 64'(ack), 64'd0);
    chk("t1_data_in", data_in, 64'd0);
    req = '0;
    tick(1);
    res = 1'b0;
    #1;
    chk("t1_owner", 64'(owner), 64'd3);
    chk("t1_state", 64'(dut.state_q), 64'(IDLE));
    chk("t1_drain", 64'(exp_q.size()), 64'd0);

    // All four requesting for 40 cycles: order 0,1,2,3,0,1,2,3, 4 words each.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_exp(i, 4);
    req = 4'b1111;
    tick(40);
    req = '0;
    chk("t3_drain", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < N; i++) begin
`ifdef FIFO_ARB_STATS_EN
      chk($sformatf("stat_%0d", i), 64'(stat_cnt[i*16 +: 16]), 64'd8);
`else
      chk($sformatf("stat_%0d", i), 64'(stat_cnt[i*16 +: 16]), 64'd0);
`endif
    end

    // Owner 1 stalled by fifo_full for 3 cycles at cnt=2, then finishes.
    push_exp(1, 4);
    req = 4'b0010;
    tick(3);
    fifo_full = 1'b1;
    repeat (3) begin
      #3;
      chk("t4_stall_shift", 64'(shift_in), 64'd0);
      chk("t4_stall_owner", 64'(owner), 64'd1);
      chk("t4_stall_cnt", 64'(dut.cnt_q), 64'd2);
      tick(1);
    end
    fifo_full = 1'b0;
    tick(2);
    req = '0;
    #1;
    chk("t4_state", 64'(dut.state_q), 64'(IDLE));
    chk("t4_drain", 64'(exp_q.size()), 64'd0);

    // Requester 0 withdraws after one word; requester 3 must win next.
    push_exp(0, 1);
    push_exp(3, 4);
    req = 4'b0001;
    tick(1);
    req = 4'b1001;
    tick(1);
    req = 4'b1000;
    tick(1);
    chk("t5_end_state", 64'(dut.state_q), 64'(IDLE));
    req = 4'b1001;
    tick(1);
    chk("t5_grant", 64'(owner), 64'd3);
    tick(4);
    req = '0;
    tick(3);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
